// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, LSB-first data, optional even parity, one stop bit
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous active-high reset
//   start          transmit request, only honoured while idle
//   DataTX         parallel word, captured when start is accepted
//   SerialDataOut  registered serial line, idles at 1 (mark)
//   busy           registered, high for every cycle of a frame
//   done           registered one-cycle pulse when the stop bit completes

module uart_tx #(
   parameter int WORD_LENGTH  = 8,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WORD_LENGTH-1:0] DataTX,
   output logic                   SerialDataOut,
   output logic                   busy,
   output logic                   done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(WORD_LENGTH);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_LENGTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t                 state, state_nxt;
   logic [CW-1:0]          baud_cnt, baud_nxt;
   logic [BW-1:0]          bit_cnt, bit_nxt;
   logic [WORD_LENGTH-1:0] shift_reg, shift_nxt;
   logic                   line_nxt, busy_nxt, done_nxt;
   logic                   bit_end;
`ifdef UART_TX_PARITY_EN
   logic                   parity_bit, parity_nxt;
`endif

   assign bit_end = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         baud_cnt      <= '0;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         SerialDataOut <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit    <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         baud_cnt      <= baud_nxt;
         bit_cnt       <= bit_nxt;
         shift_reg     <= shift_nxt;
         SerialDataOut <= line_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
`ifdef UART_TX_PARITY_EN
         parity_bit    <= parity_nxt;
`endif
      end
   end

   // The line value is computed one cycle ahead so that SerialDataOut is a
   // flop and only moves on a bit boundary or on start acceptance.
   always_comb begin
      state_nxt  = state;
      baud_nxt   = baud_cnt;
      bit_nxt    = bit_cnt;
      shift_nxt  = shift_reg;
      line_nxt   = SerialDataOut;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_nxt = parity_bit;
`endif

      case (state)
         IDLE: begin
            line_nxt = 1'b1;
            busy_nxt = 1'b0;
            if (start) begin
               shift_nxt  = DataTX;
               baud_nxt   = '0;
               bit_nxt    = '0;
`ifdef UART_TX_PARITY_EN
               parity_nxt = ^DataTX;
`endif
               state_nxt  = START;
               line_nxt   = 1'b0;
               busy_nxt   = 1'b1;
            end
         end

         START: begin
            if (bit_end) begin
               baud_nxt  = '0;
               state_nxt = DATA;
               line_nxt  = shift_reg[0];
            end else begin
               baud_nxt = baud_cnt + CW'(1);
            end
         end

         DATA: begin
            if (bit_end) begin
               baud_nxt  = '0;
               shift_nxt = shift_reg >> 1;
               if (bit_cnt == BIT_LAST) begin
                  bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
                  line_nxt  = parity_bit;
`else
                  state_nxt = STOP;
                  line_nxt  = 1'b1;
`endif
               end else begin
                  bit_nxt  = bit_cnt + BW'(1);
                  // Next data bit is the one about to land in shift_reg[0].
                  line_nxt = shift_reg[1];
               end
            end else begin
               baud_nxt = baud_cnt + CW'(1);
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               baud_nxt  = '0;
               state_nxt = STOP;
               line_nxt  = 1'b1;
            end else begin
               baud_nxt = baud_cnt + CW'(1);
            end
         end
`endif

         STOP: begin
            if (bit_end) begin
               baud_nxt  = '0;
               state_nxt = IDLE;
               line_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               baud_nxt = baud_cnt + CW'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            line_nxt  = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (WORD_LENGTH=8, CLKS_PER_BIT=4)

module tb_uart_tx;

   localparam int WL = 8;
   localparam int C  = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = WL + 3;
`else
   localparam int NB = WL + 2;
`endif
   localparam int F = NB * C;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] DataTX = 8'h00;
   logic       SerialDataOut, busy, done;

   int checks = 0;
   int errors = 0;

   uart_tx #(.WORD_LENGTH(WL), .CLKS_PER_BIT(C)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .DataTX(DataTX),
      .SerialDataOut(SerialDataOut),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // Reference model: a frame is a list of NB line levels, each held C cycles;
   // m_pos counts cycles since acceptance, -1 when idle.
   logic m_bits [0:NB-1];
   int   m_pos  = -1;
   logic m_line = 1'b1;
   logic m_busy = 1'b0;
   logic m_done = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] seq;   // start, data LSB first, stop; first transmitted at MSB
      logic       par;
   } vec_t;

   vec_t tbl [0:5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic s, input logic [7:0] d);
      m_done = 1'b0;
      if (r) begin
         m_pos = -1;
      end else if (m_pos < 0) begin
         if (s) begin
            m_bits[0] = 1'b0;
            for (int i = 0; i < WL; i++) m_bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
            m_bits[WL + 1] = ^d;
`endif
            m_bits[NB - 1] = 1'b1;
            m_pos = 0;
         end
      end else begin
         m_pos++;
         if (m_pos == F) begin
            m_pos  = -1;
            m_done = 1'b1;
         end
      end
      m_busy = (m_pos >= 0);
      m_line = (m_pos >= 0) ? m_bits[m_pos / C] : 1'b1;
   endtask

   task automatic cycle(input logic r, input logic s, input logic [7:0] d);
      reset  = r;
      start  = s;
      DataTX = d;
      model_step(r, s, d);
      @(posedge clk);
      #1;
      check("model", {SerialDataOut, busy, done}, {m_line, m_busy, m_done});
   endtask

   function automatic logic exp_bit(input vec_t v, input int k);
      if (k <= WL) return v.seq[9 - k];
`ifdef UART_TX_PARITY_EN
      if (k == WL + 1) return v.par;
`endif
      return 1'b1;
   endfunction

   // One frame checked against the table; optional second start (with new data) mid-frame.
   task automatic run_frame(input vec_t v, input int inj_at, input logic [7:0] inj_d);
      int         dones;
      logic [7:0] d;
      dones = 0;
      cycle(1'b0, 1'b1, v.data);
      check("tbl", {SerialDataOut, busy, done}, {exp_bit(v, 0), 1'b1, 1'b0});
      for (int j = 1; j <= F; j++) begin
         d = (inj_at >= 0 && j >= inj_at) ? inj_d : v.data;
         cycle(1'b0, (j == inj_at), d);
         dones += int'(done);
         if (j < F)
            check("tbl", {SerialDataOut, busy, done}, {exp_bit(v, j / C), 1'b1, 1'b0});
         else
            check("tbl_end", {SerialDataOut, busy, done}, 3'b101);
      end
      cycle(1'b0, 1'b0, v.data);
      dones += int'(done);
      check("tbl_idle", {SerialDataOut, busy, done}, 3'b100);
      check("done_count", dones, 1);
   endtask

   task automatic back_to_back();
      logic bs [0:2*F+1];
      logic ds [0:2*F+1];
      logic ls [0:2*F+1];
      int   busy_cnt, dip_cnt, gap_ones;
      cycle(1'b0, 1'b1, 8'h00);
      bs[0] = busy; ds[0] = done; ls[0] = SerialDataOut;
      for (int j = 1; j <= 2 * F + 1; j++) begin
         cycle(1'b0, 1'b1, 8'hFF);
         bs[j] = busy; ds[j] = done; ls[j] = SerialDataOut;
      end
      cycle(1'b0, 1'b0, 8'h00);
      check("b2b_idle", {SerialDataOut, busy, done}, 3'b100);
      busy_cnt = 0;
      dip_cnt  = 0;
      for (int j = 0; j <= 2 * F; j++) begin
         busy_cnt += int'(bs[j]);
         dip_cnt  += int'(!bs[j]);
      end
      gap_ones = 0;
      for (int j = F - C; j <= F; j++) gap_ones += int'(ls[j]);
      check("b2b_busy_cycles", busy_cnt, 2 * F);
      check("b2b_dip_count", dip_cnt, 1);
      check("b2b_dip_at_done", {bs[F], ds[F]}, 2'b01);
      check("b2b_gap_ones", gap_ones, C + 1);
      check("b2b_second_start", {ls[F + 1], bs[F + 1]}, 2'b01);
      check("b2b_first_data", {ls[C], ls[F + 1 + C]}, 2'b01);
      check("b2b_second_done", ds[2 * F + 1], 1);
   endtask

   initial begin
      int dones;
      logic r, s;

      tbl[0] = '{data: 8'h55, seq: 10'b0_10101010_1, par: 1'b0};
      tbl[1] = '{data: 8'hA3, seq: 10'b0_11000101_1, par: 1'b0};
      tbl[2] = '{data: 8'h07, seq: 10'b0_11100000_1, par: 1'b1};
      tbl[3] = '{data: 8'h03, seq: 10'b0_11000000_1, par: 1'b0};
      tbl[4] = '{data: 8'h0F, seq: 10'b0_11110000_1, par: 1'b0};
      tbl[5] = '{data: 8'hFE, seq: 10'b0_01111111_1, par: 1'b1};

      // Reset with start held high: nothing may start.
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 8'h55);
         check("reset", {SerialDataOut, busy, done}, 3'b100);
      end
      cycle(1'b0, 1'b0, 8'h55);
      check("post_reset_idle", {SerialDataOut, busy, done}, 3'b100);

      // Table frames; the A3 frame gets an ignored start with FF at cycle 10.
      for (int i = 0; i < 6; i++) begin
         run_frame(tbl[i], (i == 1) ? 10 : -1, 8'hFF);
         cycle(1'b0, 1'b0, 8'h00);
      end

      back_to_back();

      // Reset mid-frame at cycle 15 of an 0F frame.
      cycle(1'b0, 1'b1, 8'h0F);
      for (int j = 1; j < 15; j++) cycle(1'b0, 1'b0, 8'h0F);
      cycle(1'b1, 1'b0, 8'h0F);
      check("rst_mid", {SerialDataOut, busy, done}, 3'b100);
      dones = 0;
      for (int j = 0; j < 50; j++) begin
         cycle(1'b0, 1'b0, 8'h00);
         dones += int'(done);
      end
      check("rst_mid_no_done", dones, 0);
      run_frame(tbl[4], -1, 8'h00);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 149) == 0);
         s = ($urandom_range(0, 3) == 0);
         cycle(r, s, 8'($urandom));
      end
      cycle(1'b1, 1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter: the transmit side of the team's UART, the counterpart of the receive shift register.
- Accepts a parallel word on a single-cycle start request.
- Serialises it as an asynchronous frame: start bit, data LSB first, optional parity, one stop bit.
- Built from a baud-tick counter, a bit counter and a 4/5-state FSM.
- Sits between the host/control logic and the TX pin.

Parameters:
WORD_LENGTH, 8, data bits per frame (>=5).
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be >=2.

Ports:
clk  input  1  system clock; all logic on rising edge; one clock domain.
reset  input  1  reset; synchronous, active-high; sampled on rising edge of clk.
start  input  1  transmit request; sampled only in IDLE.
DataTX  input  WORD_LENGTH  parallel word to send; captured on start acceptance.
SerialDataOut  output  1  serial line; idle/mark = 1; registered.
busy  output  1  high while a frame is in progress; registered.
done  output  1  one-cycle pulse when the stop bit completes; registered.

Behaviour:
- Reset (reset=1 at a rising edge): state=IDLE, SerialDataOut=1, busy=0, done=0, baud/bit counters=0, shift register=0.
- Reset mid-frame aborts the frame; the line returns to 1 on that same edge, with no partial stop bit.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - SerialDataOut=1, busy=0.
  - When start=1 at an edge: latch DataTX into the shift register, clear counters, go to START.
  - On that same edge, SerialDataOut<=0 and busy<=1. Output latency from accepted start is one edge.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
  - Bit boundary when count==CLKS_PER_BIT-1; count wraps to 0.
  - Every bit is held exactly CLKS_PER_BIT cycles.
- START: line=0 for CLKS_PER_BIT cycles, then go to DATA, output bit 0.
- DATA:
  - Outputs shift_reg[0]; the register shifts right at each bit boundary.
  - Bit counter runs 0..WORD_LENGTH-1.
  - After bit WORD_LENGTH-1 completes, go to STOP (or PARITY).
- STOP:
  - Line=1 for CLKS_PER_BIT cycles.
  - At the final edge: state=IDLE, busy<=0, done<=1 for exactly one cycle.
- Frame length: (WORD_LENGTH+2)*CLKS_PER_BIT cycles, or +CLKS_PER_BIT with parity.
  - busy is high for exactly that many cycles.
- start while busy=1 is ignored; no queueing.
- DataTX changes after acceptance do not affect the frame in flight.
- Back-to-back: start=1 in the cycle done=1 (state already IDLE) is accepted. The next start bit begins on the following edge, with no extra idle bit.
- start held high continuously gives continuous back-to-back frames.
- reset and start both high at the same edge: reset wins.
- No glitches: SerialDataOut changes only at bit boundaries or on start acceptance.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Drives even parity: XOR of the latched word, computed at acceptance.
  - Held CLKS_PER_BIT cycles; frame = (WORD_LENGTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; frame = (WORD_LENGTH+2)*CLKS_PER_BIT.

Test Plan:
- Parameters for the bench: CLKS_PER_BIT=4, WORD_LENGTH=8.
- Reset: apply reset=1 for 3 cycles with start=1 -> SerialDataOut=1, busy=0, done=0; no frame starts.
- Single frame: start pulse with DataTX=8'h55 -> line sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. busy=1 for 40 cycles. done=1 for one cycle at the edge ending the stop bit, then line=1.
- Busy rejection and data stability: send 8'hA3 (bits out 1,1,0,0,0,1,0,1). Pulse start with DataTX=8'hFF at cycle 10 -> frame unchanged; only one done pulse.
- Back-to-back: hold start=1 with DataTX=8'h00 then 8'hFF -> second start bit directly follows the first stop bit (4 cycles of 1); total 80 busy cycles with a one-cycle busy dip aligned to done.
- Reset mid-frame: reset at cycle 15 of an 8'h0F frame -> line=1, busy=0 on that edge; no done pulse; a new start afterwards gives a clean full frame.
- UART_TX_PARITY_EN defined:
  - 8'h07 -> parity bit 1.
  - 8'h03 -> parity bit 0.
  - Frame 44 cycles; done at cycle 44.
